// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin OBI arbiter with an in-order ID FIFO that routes responses back to their masters
module obi_rr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS-1:0]            m_req_i,
    input  logic [NUM_MASTERS-1:0]            m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_gnt_o,
    output logic [NUM_MASTERS-1:0]            m_rvalid_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic                              s_req_o,
    output logic                              s_we_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [DATA_WIDTH/8-1:0]           s_be_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic                              s_gnt_i,
    input  logic                              s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              err_o
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int BW = DATA_WIDTH / 8;

    logic [IW-1:0] ptr, sel, rr_sel, idx, lock_idx;
    logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          lock, err, any_req, full, fire, pop;

    // Scan downward so the candidate closest to ptr is the last (winning) assignment.
    always_comb begin
        rr_sel = ptr;
        idx    = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_MASTERS);
            if (m_req_i[idx]) rr_sel = idx;
        end
    end

    assign sel           = lock ? lock_idx : rr_sel;
    assign any_req       = lock | (|m_req_i);
    assign full          = count == (AW+1)'(MAX_OUTSTANDING);
    assign s_req_o       = any_req & ~full & ~rst_i;
    assign fire          = s_req_o & s_gnt_i;
    assign pop           = s_rvalid_i & (count != '0) & ~rst_i;
    assign m_gnt_o       = fire ? NUM_MASTERS'(1) << sel : '0;
    assign m_rvalid_o    = pop ? NUM_MASTERS'(1) << fifo_q[rd_ptr] : '0;
    assign m_rdata_o     = s_rdata_i;
    assign s_we_o        = m_we_i[sel];
    assign s_addr_o      = m_addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_be_o        = m_be_i[sel*BW +: BW];
    assign s_wdata_o     = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
    assign outstanding_o = count;
    assign err_o         = err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (fire) ptr <= (sel == IW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
            if (fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            lock <= (s_req_o & ~s_gnt_i) ? 1'b1 : fire ? 1'b0 : lock;
            if (s_req_o & ~s_gnt_i) lock_idx <= sel;
            count <= count + {{AW{1'b0}}, fire} - {{AW{1'b0}}, pop};
            if (s_rvalid_i & (count == '0)) err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire) fifo_q[wr_ptr] <= sel;
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// tb_obi_rr_arbiter: directed scenario tests for obi_rr_arbiter with hand-computed expectations
module tb_obi_rr_arbiter;
    localparam int N = 4;
    localparam int AWD = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] m_req, m_we, m_gnt, m_rvalid;
    logic [N*AWD-1:0] m_addr;
    logic [N*DW/8-1:0] m_be;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata, s_wdata, s_rdata;
    logic s_req, s_we, s_gnt, s_rvalid, err;
    logic [AWD-1:0] s_addr;
    logic [DW/8-1:0] s_be;
    logic [3:0] outstanding;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; m_req = 4'b1111; s_gnt = 1'b1; s_rvalid = 1'b1;
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rst_sreq got %b exp 0", s_req); end
        checks++; if (m_gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b exp 0000", m_gnt); end
        checks++; if (m_rvalid !== 4'b0000) begin errors++; $display("FAIL rst_rvalid got %b exp 0000", m_rvalid); end
        tick();
        rst = 1'b0; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rst_outst got %0d exp 0", outstanding); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
    endtask

    task automatic test_single();
        do_reset();
        m_req = 4'b0001; s_gnt = 1'b1; m_we[0] = 1'b1; m_wdata[31:0] = 32'h1234_5678;
        #1;
        checks++; if (m_gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b exp 0001", m_gnt); end
        checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL single_addr got %h exp 00000100", s_addr); end
        checks++; if (s_we !== 1'b1 || s_wdata !== 32'h1234_5678) begin errors++; $display("FAIL single_wr got %b/%h exp 1/12345678", s_we, s_wdata); end
        tick();
        m_req = '0; s_gnt = 1'b0; m_we[0] = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL single_outst1 got %0d exp 1", outstanding); end
        tick();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (m_rvalid !== 4'b0001) begin errors++; $display("FAIL single_rvalid got %b exp 0001", m_rvalid); end
        checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", m_rdata); end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_outst0 got %0d exp 0", outstanding); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        do_reset();
        m_req = 4'b1111; s_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            #1;
            checks++; if (m_gnt !== eg) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", k, m_gnt, eg); end
            checks++; if (s_addr !== 32'h1000 + 32'((k % 4) * 16)) begin errors++; $display("FAIL rr_addr%0d got %h", k, s_addr); end
            tick();
        end
        m_req = '0; s_gnt = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd5) begin errors++; $display("FAIL rr_outst got %0d exp 5", outstanding); end
        s_rvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            s_rdata = 32'hA000 + 32'(k);
            #1;
            checks++; if (m_rvalid !== eg) begin errors++; $display("FAIL rr_rvalid%0d got %b exp %b", k, m_rvalid, eg); end
            checks++; if (m_rdata !== 32'hA000 + 32'(k)) begin errors++; $display("FAIL rr_rdata%0d got %h", k, m_rdata); end
            tick();
        end
        s_rvalid = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rr_drain got %0d exp 0", outstanding); end
    endtask

    task automatic test_stall_lock();
        do_reset();
        m_req = 4'b0010; s_gnt = 1'b0;
        #1;
        checks++; if (s_req !== 1'b1 || m_gnt !== 4'b0000) begin errors++; $display("FAIL lock_c0 got req %b gnt %b exp 1/0000", s_req, m_gnt); end
        checks++; if (s_addr !== 32'h1010) begin errors++; $display("FAIL lock_c0_addr got %h exp 00001010", s_addr); end
        tick();
        m_req = 4'b0011;
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++; if (s_addr !== 32'h1010 || m_gnt !== 4'b0000) begin errors++; $display("FAIL lock_c%0d got addr %h gnt %b exp 00001010/0000", c, s_addr, m_gnt); end
            tick();
        end
        s_gnt = 1'b1;
        #1;
        checks++; if (m_gnt !== 4'b0010 || s_addr !== 32'h1010) begin errors++; $display("FAIL lock_grant got gnt %b addr %h exp 0010/00001010", m_gnt, s_addr); end
        tick();
        m_req = 4'b0001;
        #1;
        checks++; if (m_gnt !== 4'b0001 || s_addr !== 32'h1000) begin errors++; $display("FAIL lock_next got gnt %b addr %h exp 0001/00001000", m_gnt, s_addr); end
        tick();
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        #1;
        checks++; if (m_rvalid !== 4'b0010) begin errors++; $display("FAIL lock_resp0 got %b exp 0010", m_rvalid); end
        tick();
        #1;
        checks++; if (m_rvalid !== 4'b0001) begin errors++; $display("FAIL lock_resp1 got %b exp 0001", m_rvalid); end
        tick();
        s_rvalid = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        m_req = 4'b0001; s_gnt = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        s_rvalid = 1'b1;
        #1;
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL full_outst got %0d exp 8", outstanding); end
        checks++; if (s_req !== 1'b0 || m_gnt !== 4'b0000) begin errors++; $display("FAIL full_block got req %b gnt %b exp 0/0000", s_req, m_gnt); end
        checks++; if (m_rvalid !== 4'b0001) begin errors++; $display("FAIL full_pop got %b exp 0001", m_rvalid); end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd7) begin errors++; $display("FAIL full_outst7 got %0d exp 7", outstanding); end
        checks++; if (s_req !== 1'b1 || m_gnt !== 4'b0001) begin errors++; $display("FAIL full_resume got req %b gnt %b exp 1/0001", s_req, m_gnt); end
        tick();
        m_req = '0; s_gnt = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL full_refill got %0d exp 8", outstanding); end
        s_rvalid = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL full_drain got %0d exp 0", outstanding); end
    endtask

    task automatic test_spurious();
        do_reset();
        s_rvalid = 1'b1;
        #1;
        checks++; if (m_rvalid !== 4'b0000 || err !== 1'b0) begin errors++; $display("FAIL spur_c0 got rvalid %b err %b exp 0000/0", m_rvalid, err); end
        tick();
        s_rvalid = 1'b0;
        #1;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_err got %b exp 1", err); end
        for (int k = 0; k < 3; k++) tick();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL spur_sticky got %b exp 1", err); end
    endtask

    task automatic test_reset_mid();
        m_req = 4'b0111; s_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (m_gnt !== (4'b0001 << k)) begin errors++; $display("FAIL mid_gnt%0d got %b", k, m_gnt); end
            tick();
        end
        m_req = 4'b0010; s_gnt = 1'b0;
        tick();
        checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL mid_outst got %0d exp 3", outstanding); end
        rst = 1'b1;
        #1;
        checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL mid_rst_sreq got %b exp 0", s_req); end
        tick();
        rst = 1'b0; m_req = 4'b1100; s_gnt = 1'b1;
        #1;
        checks++; if (outstanding !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_cleared got outst %0d err %b exp 0/0", outstanding, err); end
        checks++; if (m_gnt !== 4'b0100) begin errors++; $display("FAIL mid_first got %b exp 0100", m_gnt); end
        tick();
        m_req = '0; s_gnt = 1'b0;
    endtask

    initial begin
        rst = 1'b1; m_req = '0; m_we = '0; m_be = '1; m_wdata = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        for (int i = 0; i < N; i++) m_addr[i*AWD +: AWD] = 32'h1000 + 32'(i * 16);
        m_addr[31:0] = 32'h100;
        tick();
        test_reset();
        test_single();
        m_addr[31:0] = 32'h1000;
        test_round_robin();
        test_stall_lock();
        test_fifo_full();
        test_spurious();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obi_rr_arbiter.md
Name: obi_rr_arbiter

Overview:
- Shares one OBI port of the OBI-to-AXI bridge between NUM_MASTERS OBI requesters (e.g. LLC controller, DMA, debug) using round-robin arbitration.
- Records the master index of every granted request in an in-order ID FIFO so each response is routed back to the master that issued it.
- Sits directly upstream of the OBI-to-AXI bridge.
- Fully synchronous: one clock, synchronous active-high reset.

Parameters:
- NUM_MASTERS, 4, number of upstream OBI requesters (2..16).
- ADDR_WIDTH, 32, OBI address width.
- DATA_WIDTH, 32, OBI read/write data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 8, depth of the ID FIFO, i.e. the maximum number of granted requests still awaiting rvalid (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- m_req_i  in  NUM_MASTERS  per-master OBI req.
- m_we_i  in  NUM_MASTERS  per-master write enable.
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  per-master address, packed with master 0 in the LSBs.
- m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  per-master byte enables.
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  per-master write data.
- m_gnt_o  out  NUM_MASTERS  per-master grant.
- m_rvalid_o  out  NUM_MASTERS  per-master response valid.
- m_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters.
- s_req_o  out  1  downstream req.
- s_we_o  out  1  downstream write enable.
- s_addr_o  out  ADDR_WIDTH  downstream address.
- s_be_o  out  DATA_WIDTH/8  downstream byte enables.
- s_wdata_o  out  DATA_WIDTH  downstream write data.
- s_gnt_i  in  1  downstream grant.
- s_rvalid_i  in  1  downstream response valid.
- s_rdata_i  in  DATA_WIDTH  downstream read data.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy.
- err_o  out  1  sticky flag: rvalid received with no outstanding request.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - round-robin pointer = 0; lock cleared; FIFO empty; outstanding_o=0; err_o=0.
  - While rst_i is high, s_req_o, all m_gnt_o and all m_rvalid_o are forced to 0.
  - Reset mid-transaction discards all in-flight IDs; the downstream bridge is reset in the same cycle.
- Selection (combinational):
  - If lock is set, sel = locked index.
  - Otherwise sel = first index with m_req_i set, searching from ptr upward and wrapping mod NUM_MASTERS.
  - s_req_o = any request & !fifo_full (a locked request is still held at 0 while the FIFO is full).
  - s_we/addr/be/wdata are muxed from sel; they are don't-care when s_req_o=0.
- Grant:
  - m_gnt_o[sel] = s_req_o & s_gnt_i; all other bits are 0.
  - Zero-cycle pass-through: same-cycle req to gnt when downstream grants immediately.
- Handshake (fire = s_req_o & s_gnt_i):
  - OBI rule: a req must stay asserted with stable fields until granted.
  - Lock: set when s_req_o=1 and s_gnt_i=0, storing sel; cleared on fire. This prevents re-arbitration while a request is pending.
  - On fire: push sel into the FIFO; ptr <= (sel+1) mod NUM_MASTERS.
  - When no fire occurs, ptr is unchanged.
- Response routing:
  - On s_rvalid_i with FIFO non-empty: m_rvalid_o[head]=1 for one cycle; m_rdata_o = s_rdata_i; head is popped.
  - Responses return in order because OBI and the bridge are in-order.
  - On s_rvalid_i with FIFO empty: no m_rvalid_o asserted; err_o <= 1 and stays 1 until reset.
- FIFO occupancy:
  - fifo_full = (count == MAX_OUTSTANDING).
  - Simultaneous push and pop: count is unchanged; the pop takes the old head. If the FIFO was empty, the new entry becomes head next cycle; same-cycle grant+response is impossible.
  - When full, no push is allowed even if a pop occurs in the same cycle (conservative). s_req_o returns one cycle after count drops.
- Width rules:
  - ptr and FIFO entries are $clog2(NUM_MASTERS) bits.
  - Wrap of ptr at NUM_MASTERS-1 goes to 0; FIFO read/write pointers wrap naturally.
- Fairness bound: a continuously requesting master is granted within NUM_MASTERS grants.

Test Plan:
- Single master: m_req_i=0001, addr 0x100, s_gnt_i=1 same cycle → m_gnt_o=0001 same cycle, s_addr_o=0x100. s_rvalid_i two cycles later with rdata 0xDEADBEEF → m_rvalid_o=0001, m_rdata_o=0xDEADBEEF, outstanding_o 1→0.
- Round-robin: m_req_i=1111 held, s_gnt_i=1 every cycle → grant order 0,1,2,3,0. Responses returned in order → m_rvalid_o order 0001,0010,0100,1000,0001.
- Stall/lock: master 1 requests with s_gnt_i=0 for 3 cycles; master 0 raises req in cycle 2 → s_addr_o stays at master 1's value, m_gnt_o=0010 on the grant cycle, then master 0 is granted next.
- FIFO full (MAX_OUTSTANDING=8): 8 grants with no rvalid → outstanding_o=8, s_req_o=0 despite pending req. One s_rvalid_i → s_req_o reasserted the following cycle, outstanding_o=7 then back to 8 on the next grant.
- Spurious response: s_rvalid_i with outstanding_o=0 → m_rvalid_o=0000, err_o=1 from the next cycle, held until rst_i.
- Reset mid-operation: 3 outstanding plus a locked pending request, then rst_i=1 for 1 cycle → outstanding_o=0, err_o=0, s_req_o=0 during reset; the next m_req_i=0100 is granted first (ptr=0 search).
